// File: rtl/dec_nbit_seq.sv
// dec_nbit_seq: registered N-to-2^N one-hot decoder with valid/ready input and optional auto-scan (enabled by DEC_SCAN_EN)
module dec_nbit_seq #(
  parameter int N     = 4,
  parameter int DWELL = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic           mode,
  output logic           out_valid,
  output logic [2**N-1:0] s,
  output logic [N-1:0]   cur_idx,
  output logic           busy
);
  localparam int M = 2**N;
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  state_t state, state_d;
  logic [N-1:0] idx_d;
  logic [M-1:0] s_d;
  logic ov_d, accept;
  assign in_ready = en & (state != SCAN);
  assign accept = in_valid & in_ready;
  assign busy = state == SCAN;
`ifdef DEC_SCAN_EN
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);
  logic [CW-1:0] cnt, cnt_d;
  // next state: disable wins, then accept, then scan stepping or drop to HOLD when mode falls
  always_comb begin
    state_d = state;
    idx_d = cur_idx;
    cnt_d = cnt;
    ov_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d = '0;
    end else if (accept) begin
      state_d = mode ? SCAN : HOLD;
      idx_d = a;
      ov_d = 1'b1;
      cnt_d = RELOAD;
    end else if (state == SCAN) begin
      if (!mode) state_d = HOLD;
      else if (cnt == '0) begin
        idx_d = cur_idx + N'(1);
        cnt_d = RELOAD;
      end else cnt_d = cnt - CW'(1);
    end
    s_d = (state_d == IDLE) ? '0 : M'(1) << idx_d;
  end
  // dwell counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
  // next state without scan: disable wins, accept replaces, otherwise hold
  always_comb begin
    state_d = state;
    idx_d = cur_idx;
    ov_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d = '0;
    end else if (accept) begin
      state_d = HOLD;
      idx_d = a;
      ov_d = 1'b1;
    end
    s_d = (state_d == IDLE) ? '0 : M'(1) << idx_d;
  end
`endif
  // state and output registers; s is registered so it is glitch-free one-hot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cur_idx <= '0;
      out_valid <= 1'b0;
      s <= '0;
    end else begin
      state <= state_d;
      cur_idx <= idx_d;
      out_valid <= ov_d;
      s <= s_d;
    end
endmodule

// File: tb/tb_dec_nbit_seq.sv
// tb_dec_nbit_seq: randomized and directed checks of dec_nbit_seq against a behavioural model
module tb_dec_nbit_seq;
  localparam int N = 4, DWELL = 2, M = 2**N;
`ifdef DEC_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif
  logic clk = 0, rst_n = 0, en = 0, in_valid = 0, mode = 0;
  logic [N-1:0] a = '0;
  logic in_ready, out_valid, busy;
  logic [M-1:0] s;
  logic [N-1:0] cur_idx;
  int total = 0, bad = 0;
  bit m_act, m_scan, m_ov, exp_rdy, rdy_seen;
  int m_idx, m_age;

  dec_nbit_seq #(.N(N), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .mode(mode), .out_valid(out_valid), .s(s), .cur_idx(cur_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] exp_s();
    logic [M-1:0] r = '0;
    if (m_act) r[m_idx] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_act = 0; m_scan = 0; m_ov = 0; m_idx = 0; m_age = 0;
  endtask

  task automatic drive(input logic e, input logic v, input logic [N-1:0] aa, input logic md);
    en = e; in_valid = v; a = aa; mode = md;
    exp_rdy = e && !m_scan;
    #1 rdy_seen = in_ready;
    @(posedge clk);
    if (!e) begin
      m_act = 0; m_scan = 0; m_ov = 0; m_idx = 0;
    end else if (v && exp_rdy) begin
      m_act = 1; m_idx = int'(aa); m_scan = SCAN_ON && md; m_age = 1; m_ov = 1;
    end else begin
      m_ov = 0;
      if (m_scan) begin
        if (!md) m_scan = 0;
        else if (m_age == DWELL) begin m_idx = (m_idx + 1) % M; m_age = 1; end
        else m_age++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h exp=0", s); end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags got ov=%b busy=%b exp 0 0", out_valid, busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", in_ready); end
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    drive(1, 1, 4'd7, 1);
    drive(1, 0, 4'd0, 1);
    #2 rst_n = 0;
    #1;
    total++; if (s !== '0 || cur_idx !== '0) begin bad++; $display("FAIL async_reset got s=%h idx=%0d exp 0 0", s, cur_idx); end
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_flags got ov=%b busy=%b exp 0 0", out_valid, busy); end
    model_reset();
    en = 0; in_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rdy_en0 got=%b exp=0", in_ready); end
  endtask

  task automatic test_direct();
    drive(1, 1, 4'hA, 0);
    total++; if (s !== 16'h0400 || cur_idx !== 4'hA) begin bad++; $display("FAIL direct got s=%h idx=%h exp 0400 a", s, cur_idx); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL direct_ov got=%b exp=1", out_valid); end
    drive(1, 0, 4'h2, 0);
    total++; if (s !== 16'h0400 || out_valid !== 1'b0) begin bad++; $display("FAIL direct_hold got s=%h ov=%b exp 0400 0", s, out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 4'd3, 0);
    total++; if (s !== 16'h0008 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got s=%h ov=%b exp 0008 1", s, out_valid); end
    drive(1, 1, 4'd15, 0);
    total++; if (s !== 16'h8000 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got s=%h ov=%b exp 8000 1", s, out_valid); end
    total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL b2b_rdy got=%b exp=1", rdy_seen); end
  endtask

  task automatic test_scan();
`ifdef DEC_SCAN_EN
    logic [M-1:0] seq [5] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h0001};
    logic [N-1:0] start = 4'd14;
    logic exp_busy = 1'b1;
`else
    logic [M-1:0] seq [5] = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
    logic [N-1:0] start = 4'd5;
    logic exp_busy = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, start, 1);
      total++; if (s !== seq[i]) begin bad++; $display("FAIL scan_s[%0d] got=%h exp=%h", i, s, seq[i]); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL scan_busy[%0d] got=%b exp=%b", i, busy, exp_busy); end
      total++; if (out_valid !== (i == 0)) begin bad++; $display("FAIL scan_ov[%0d] got=%b exp=%b", i, out_valid, i == 0); end
      if (i > 0) begin
        total++; if (rdy_seen !== !exp_busy) begin bad++; $display("FAIL scan_rdy[%0d] got=%b exp=%b", i, rdy_seen, !exp_busy); end
      end
    end
  endtask

  task automatic test_disable();
    drive(0, 1, 4'd9, 1);
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL dis_rdy got=%b exp=0", rdy_seen); end
    total++; if (s !== '0 || cur_idx !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL disable got s=%h idx=%0d busy=%b ov=%b exp all 0", s, cur_idx, busy, out_valid); end
    drive(1, 0, 4'd9, 0);
    total++; if (s !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL dis_idle got s=%h ov=%b exp 0 0", s, out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0, N'($urandom), $urandom_range(0, 5) != 0);
      total++; if (s !== exp_s() || cur_idx !== N'(m_idx)) begin bad++; $display("FAIL rand_s[%0d] got s=%h idx=%0d exp s=%h idx=%0d", i, s, cur_idx, exp_s(), m_idx); end
      total++; if (out_valid !== m_ov || busy !== m_scan) begin bad++; $display("FAIL rand_flags[%0d] got ov=%b busy=%b exp ov=%b busy=%b", i, out_valid, busy, m_ov, m_scan); end
      total++; if (rdy_seen !== exp_rdy) begin bad++; $display("FAIL rand_rdy[%0d] got=%b exp=%b", i, rdy_seen, exp_rdy); end
      total++; if ($countones(s) > 1) begin bad++; $display("FAIL rand_onehot[%0d] got=%h exp at most one bit", i, s); end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_scan();
    test_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
